// File: rtl/frame_buf_ctrl.sv
// Frame buffer controller: rotates four SDRAM frame buffers between the
// CMOS writer and the VGA/SD readers, with photo freeze and drop tracking.
module frame_buf_ctrl #(
  parameter bit VS_POL      = 1'b1,
  parameter int SKIP_FRAMES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmos_vsync,
  output logic             write_req,
  input  logic             write_req_ack,
  output logic [1:0]       write_addr_index,
  output logic [1:0]       read_addr_index,
  input  logic             photo_save,
  input  logic             saved,
  output logic             frozen,
  output logic             frame_done,
  output logic             frame_drop,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    SKIP,
    WAIT_VS,
    REQ,
    WRITING
  } state_e;

  localparam state_e     RST_ST = (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
  localparam logic [7:0] SKIP_N = 8'(SKIP_FRAMES);

  state_e state_q, state_d;

  logic             vs_d0_q, vs_d1_q;
  logic             edge_w;
  logic [7:0]       skip_q, skip_d;
  logic             req_q, req_d;
  logic [1:0]       wi_q, wi_d;
  logic [1:0]       ri_q, ri_d;
  logic [1:0]       nxt;
  logic             frz_q, frz_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;

  assign edge_w = (vs_d0_q == VS_POL) && (vs_d1_q != VS_POL);

  always_ff @(posedge clk) begin
    if (rst) state_q <= RST_ST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SKIP:    if (edge_w && (skip_q + 8'd1 == SKIP_N)) state_d = WAIT_VS;
      WAIT_VS: if (edge_w) state_d = REQ;
      REQ:     if (write_req_ack) state_d = WRITING;
      WRITING: if (edge_w) state_d = REQ;
      default: state_d = RST_ST;
    endcase
  end

  // A freeze landing on the same cycle as a frame edge already holds the read index.
  always_comb begin
    skip_d = skip_q;
    req_d  = (state_d == REQ);
    wi_d   = wi_q;
    ri_d   = ri_q;
    nxt    = wi_q + 2'd1;
    frz_d  = saved ? 1'b0 : (photo_save ? 1'b1 : frz_q);
    done_d = 1'b0;
    drop_d = 1'b0;
    fcnt_d = fcnt_q;
    dcnt_d = dcnt_q;
    unique case (state_q)
      SKIP: if (edge_w) skip_d = skip_q + 8'd1;
      REQ: begin
        if (!write_req_ack && edge_w) begin
          drop_d = 1'b1;
          if (dcnt_q != '1) dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      WRITING: begin
        if (edge_w) begin
          done_d = 1'b1;
          fcnt_d = fcnt_q + CNT_W'(1);
          if (!frz_d) ri_d = wi_q;
          if (nxt == ri_d) nxt = nxt + 2'd1;
          wi_d = nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d0_q <= VS_POL;
      vs_d1_q <= VS_POL;
      skip_q  <= '0;
      req_q   <= 1'b0;
      wi_q    <= 2'd1;
      ri_q    <= 2'd0;
      frz_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      vs_d0_q <= cmos_vsync;
      vs_d1_q <= vs_d0_q;
      skip_q  <= skip_d;
      req_q   <= req_d;
      wi_q    <= wi_d;
      ri_q    <= ri_d;
      frz_q   <= frz_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign write_req        = req_q;
  assign write_addr_index = wi_q;
  assign read_addr_index  = ri_q;
  assign frozen           = frz_q;
  assign frame_done       = done_q;
  assign frame_drop       = drop_q;
  assign frame_cnt        = fcnt_q;
  assign drop_cnt         = dcnt_q;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Scoreboard bench for frame_buf_ctrl: a behavioural model predicts every
// cycle's outputs; a negedge monitor pops and compares.
module tb_frame_buf_ctrl;

  localparam int SKIP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b0;
  logic        ack = 1'b0;
  logic        ps = 1'b0;
  logic        sv = 1'b0;
  logic        write_req, frozen, frame_done, frame_drop;
  logic [1:0]  wi, ri;
  logic [15:0] fcnt, dcnt;

  frame_buf_ctrl #(.VS_POL(1'b1), .SKIP_FRAMES(SKIP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmos_vsync(vs),
    .write_req(write_req), .write_req_ack(ack),
    .write_addr_index(wi), .read_addr_index(ri),
    .photo_save(ps), .saved(sv), .frozen(frozen),
    .frame_done(frame_done), .frame_drop(frame_drop),
    .frame_cnt(fcnt), .drop_cnt(dcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [1:0]  wi, ri;
    logic        frz, done, drop;
    logic [15:0] fc, dc;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: settled-edge count, pending request, frame in flight.
  int m_seen;
  bit m_pending, m_busy, m_frz, m_done, m_drop;
  int m_wi, m_ri, m_fc, m_dc;
  bit h1, h2;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit a,
                       input bit p, input bit s);
    bit edge_seen, frz_now;
    if (r) begin
      m_seen = 0; m_pending = 0; m_busy = 0; m_frz = 0;
      m_wi = 1; m_ri = 0; m_fc = 0; m_dc = 0;
      m_done = 0; m_drop = 0; h1 = 1; h2 = 1;
      return;
    end
    edge_seen = h1 && !h2;
    m_done = 0;
    m_drop = 0;
    frz_now = s ? 1'b0 : (p ? 1'b1 : m_frz);
    if (m_seen < SKIP) begin
      if (edge_seen) m_seen++;
    end else if (m_pending) begin
      if (a) begin
        m_pending = 0;
        m_busy = 1;
      end else if (edge_seen) begin
        m_drop = 1;
        if (m_dc < 65535) m_dc++;
      end
    end else if (m_busy) begin
      if (edge_seen) begin
        m_done = 1;
        m_fc = (m_fc + 1) % 65536;
        if (!frz_now) m_ri = m_wi;
        m_wi = (m_wi + 1) % 4;
        if (m_wi == m_ri) m_wi = (m_wi + 1) % 4;
        m_busy = 0;
        m_pending = 1;
      end
    end else if (edge_seen) begin
      m_pending = 1;
    end
    m_frz = frz_now;
    h2 = h1;
    h1 = v;
  endtask

  task automatic step(input bit r, input bit v, input bit a,
                      input bit p, input bit s);
    exp_t e;
    rst = r; vs = v; ack = a; ps = p; sv = s;
    model(r, v, a, p, s);
    e.req = m_pending;
    e.wi = 2'(m_wi);
    e.ri = 2'(m_ri);
    e.frz = m_frz;
    e.done = m_done;
    e.drop = m_drop;
    e.fc = 16'(m_fc);
    e.dc = 16'(m_dc);
    @(posedge clk);
    sbq.push_back(e);
    #1;
  endtask

  task automatic vpulse(input bit a);
    for (int i = 0; i < 3; i++) step(0, 1, a, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, a, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("write_req", int'(write_req), int'(e.req));
      chk("write_idx", int'(wi), int'(e.wi));
      chk("read_idx", int'(ri), int'(e.ri));
      chk("frozen", int'(frozen), int'(e.frz));
      chk("frame_done", int'(frame_done), int'(e.done));
      chk("frame_drop", int'(frame_drop), int'(e.drop));
      chk("frame_cnt", int'(fcnt), int'(e.fc));
      chk("drop_cnt", int'(dcnt), int'(e.dc));
      chk("idx_distinct", int'(wi != ri), 1);
    end
  end

  initial begin
    int r, v;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    // settling pulses, then the first request and its ack
    for (int i = 0; i < 3; i++) vpulse(0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // rotation with ack held high, then freeze and release
    for (int i = 0; i < 2; i++) vpulse(1);
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) vpulse(1);
    step(0, 0, 1, 0, 1);
    vpulse(1);
    // late ack across two boundaries
    vpulse(0);
    vpulse(0);
    vpulse(0);
    step(0, 0, 1, 0, 0);
    // freeze corner cases
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    // reset while a request is pending
    vpulse(0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) vpulse(1);
    // randomized traffic
    v = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) v = 1 - v;
      r = ($urandom_range(0, 799) == 0) ? 1 : 0;
      step(r[0], v[0], ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0));
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_buf_ctrl.md
Name: frame_buf_ctrl

Overview:
- Manages the four SDRAM frame buffers shared by the CMOS write path and the VGA/SD read paths. Runs in the cmos_pclk domain.
- Detects sensor frame boundaries and issues the per-frame write request handshake to the frame writer.
- Rotates the write buffer index and publishes the index of the newest complete frame as the read index.
- Freezes the read buffer while a photo is saved to SD, so the saved frame is never overwritten.

Parameters:
- VS_POL, 1: active level of cmos_vsync. A frame boundary is the transition into this level.
- SKIP_FRAMES, 2: number of frame boundaries ignored after reset while the sensor settles. Range 0..255.
- CNT_W, 16: width of frame_cnt and drop_cnt.

Ports:
- clk  in  1  pixel clock, connected to cmos_pclk
- rst  in  1  synchronous active-high reset
- cmos_vsync  in  1  sensor vertical sync, already synchronous to clk
- write_req  out  1  request to start writing a frame into buffer write_addr_index
- write_req_ack  in  1  frame writer accepted the request (level, may be held)
- write_addr_index  out  2  buffer currently being written
- read_addr_index  out  2  buffer holding the newest complete or frozen frame
- photo_save  in  1  one-cycle pulse: freeze read_addr_index
- saved  in  1  one-cycle pulse: release freeze
- frozen  out  1  freeze active
- frame_done  out  1  one-cycle pulse when a frame completes
- frame_drop  out  1  one-cycle pulse when a boundary arrives before the ack
- frame_cnt  out  CNT_W  completed frames, wraps
- drop_cnt  out  CNT_W  dropped frames, saturates at all-ones

Behaviour:
- Edge detect: vs_d0 <= cmos_vsync and vs_d1 <= vs_d0. edge = (vs_d0 == VS_POL) && (vs_d1 != VS_POL). All actions are registered on edge, so outputs change 2 clk cycles after vsync is first sampled active.
- Reset values:
  - write_req = 0, write_addr_index = 1, read_addr_index = 0
  - frozen = 0, frame_done = 0, frame_drop = 0
  - frame_cnt = 0, drop_cnt = 0, skip counter = 0
  - state = SKIP, or WAIT_VS if SKIP_FRAMES = 0
  - Reset mid-operation aborts immediately: write_req drops the next cycle and no frame_done is issued.
- State machine:
  - SKIP: each edge increments the skip counter. On the edge that brings it to SKIP_FRAMES, go to WAIT_VS. That edge does not start a frame.
  - WAIT_VS: on edge, write_req <= 1 and go to REQ.
  - REQ: hold write_req high.
    - If write_req_ack = 1: write_req <= 0, go to WRITING.
    - If edge occurs with no ack in the same cycle: frame_drop pulse, drop_cnt++, stay in REQ with write_req still high, indices unchanged.
    - If ack and edge occur in the same cycle: ack wins; treat as ack only.
  - WRITING: on edge the frame is complete.
    - frame_done pulse, frame_cnt++.
    - If not frozen: read_addr_index <= write_addr_index.
    - write_addr_index <= next index (see rule below).
    - write_req <= 1, go to REQ.
- Next write index:
  - n = (write_addr_index + 1) mod 4, using 2-bit wrap.
  - If n equals the new read_addr_index, n = n + 1 mod 4.
  - Invariant: write_addr_index != read_addr_index in every cycle.
- Freeze:
  - photo_save sets frozen; saved clears it.
  - Both in the same cycle: saved wins (frozen <= 0).
  - photo_save while already frozen: no effect.
  - A freeze that takes effect in the same cycle as a WRITING edge applies to that edge: read index is held.
- frozen only gates updates to read_addr_index. Writing continues and rotates through the three non-read buffers.
- write_req_ack outside REQ is ignored.
- Edges in WAIT_VS never drop.

Test Plan:
- Reset check: assert rst for 3 cycles -> write_req=0, write_addr_index=1, read_addr_index=0, frozen=0, both counters 0.
- Settling skip with SKIP_FRAMES=2: vsync pulses 1 and 2 -> write_req stays 0. Pulse 3 -> write_req=1 exactly 2 clk after vsync rises. ack -> write_req=0 the next cycle.
- Normal rotation with immediate acks over 4 frames:
  - Pairs (read, write) go (1,2), (2,3), (3,0), (0,1).
  - frame_done pulses 4 times; frame_cnt=4.
- Freeze: at read=2, write=3, pulse photo_save, then 4 frames.
  - write goes 0, 1, 3, 0, never 2; read stays 2; frozen=1.
  - Pulse saved, then 1 frame -> read=0, write=1, frozen=0.
- Late ack: in REQ, withhold ack across 2 vsync edges -> 2 frame_drop pulses, drop_cnt=2, indices unchanged, write_req held high. Then ack -> WRITING.
- Corner events:
  - photo_save and saved in the same cycle -> frozen=0.
  - rst asserted while in REQ -> next cycle write_req=0, write=1, read=0, state SKIP.
